// File: rtl/service_counter_queue.sv
// ============================================================================
// Module  : service_counter_queue
// Brief   : Three-counter service dispatcher fed by a DEPTH-entry FIFO.
//           Optional drop counter enabled by DROP_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module service_counter_queue #(
  parameter int DEPTH  = 3,
  parameter int NUM_W  = 4,
  parameter int TIME_W = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  input  logic [NUM_W-1:0]                   in_num,
  input  logic [TIME_W-1:0]                  in_time,
  output logic [NUM_W-1:0]                   num1,
  output logic [NUM_W-1:0]                   num2,
  output logic [NUM_W-1:0]                   num3,
  output logic [TIME_W-1:0]                  clk1,
  output logic [TIME_W-1:0]                  clk2,
  output logic [TIME_W-1:0]                  clk3,
  output logic [(NUM_W+TIME_W)*DEPTH-1:0]    qdbg,
  output logic                               fifo_re,
  output logic                               ld1,
  output logic                               ld2,
  output logic                               ld3,
  output logic [2:0]                         busy,
  output logic                               fifo_full,
  output logic                               fifo_emp,
  output logic [NUM_W-1:0]                   fifo_num,
  output logic [TIME_W-1:0]                  fifo_tim,
  output logic [NUM_W-1:0]                   dn1,
  output logic [TIME_W-1:0]                  dt1,
  output logic [NUM_W-1:0]                   dn2,
  output logic [TIME_W-1:0]                  dt2,
  output logic [NUM_W-1:0]                   dn3,
  output logic [TIME_W-1:0]                  dt3
`ifdef DROP_COUNT_EN
  ,
  output logic [7:0]                         drop_cnt
`endif
);

  localparam int                 c_ENT_W = NUM_W + TIME_W;
  localparam int                 c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  logic [NUM_W-1:0]   r_num [3];
  logic [TIME_W-1:0]  r_clk [3];
  logic [c_ENT_W-1:0] r_q   [DEPTH];
  logic [c_CNT_W-1:0] r_cnt;

  logic [2:0]         w_free, w_pop_sel, w_rem, w_byp_sel, w_ld;
  logic               w_arr, w_pop, w_byp, w_push;
  logic [NUM_W-1:0]   w_dn [3];
  logic [TIME_W-1:0]  w_dt [3];
  logic [c_ENT_W-1:0] w_q_nxt [DEPTH];
  logic [c_CNT_W-1:0] w_cnt_pop, w_cnt_nxt;

  always_comb begin
    for (int i = 0; i < 3; i++) w_free[i] = (r_clk[i] == '0);
    // Arrivals are ignored while reset is held so every output reads idle.
    w_arr     = in_valid && (in_time != '0) && !rst_n;
    w_pop     = (r_cnt != '0) && (|w_free);
    w_pop_sel = w_pop ? (w_free & (~w_free + 3'd1)) : 3'b000;
    w_rem     = w_free & ~w_pop_sel;
    w_byp     = w_arr && (r_cnt == '0) && (|w_rem);
    w_byp_sel = w_byp ? (w_rem & (~w_rem + 3'd1)) : 3'b000;
    w_push    = w_arr && !w_byp && ((r_cnt != c_DEPTH) || w_pop);
    w_ld      = w_pop_sel | w_byp_sel;
    for (int i = 0; i < 3; i++) begin
      w_dn[i] = '0;
      w_dt[i] = '0;
      if (w_pop_sel[i]) begin
        w_dn[i] = r_q[0][c_ENT_W-1:TIME_W];
        w_dt[i] = r_q[0][TIME_W-1:0];
      end else if (w_byp_sel[i]) begin
        w_dn[i] = in_num;
        w_dt[i] = in_time;
      end
    end
    // Shift-register FIFO: pop shifts toward the head, push lands behind the last entry.
    w_cnt_pop = w_pop ? (r_cnt - c_CNT_W'(1)) : r_cnt;
    for (int k = 0; k < DEPTH - 1; k++) w_q_nxt[k] = w_pop ? r_q[k+1] : r_q[k];
    w_q_nxt[DEPTH-1] = w_pop ? '0 : r_q[DEPTH-1];
    for (int k = 0; k < DEPTH; k++) begin
      if (w_push && (c_CNT_W'(k) == w_cnt_pop)) w_q_nxt[k] = {in_num, in_time};
    end
    w_cnt_nxt = w_push ? (w_cnt_pop + c_CNT_W'(1)) : w_cnt_pop;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) r_q[k] <= '0;
      for (int i = 0; i < 3; i++) begin
        r_num[i] <= '0;
        r_clk[i] <= '0;
      end
    end else begin
      r_cnt <= w_cnt_nxt;
      for (int k = 0; k < DEPTH; k++) r_q[k] <= w_q_nxt[k];
      for (int i = 0; i < 3; i++) begin
        if (w_ld[i]) begin
          r_num[i] <= w_dn[i];
          r_clk[i] <= w_dt[i];
        end else if (!w_free[i]) begin
          r_clk[i] <= r_clk[i] - TIME_W'(1);
          if (r_clk[i] == TIME_W'(1)) r_num[i] <= '0;
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_qdbg
      assign qdbg[c_ENT_W*k +: c_ENT_W] = r_q[k];
    end
  endgenerate

  assign num1      = r_num[0];
  assign num2      = r_num[1];
  assign num3      = r_num[2];
  assign clk1      = r_clk[0];
  assign clk2      = r_clk[1];
  assign clk3      = r_clk[2];
  assign fifo_re   = w_pop;
  assign ld1       = w_ld[0];
  assign ld2       = w_ld[1];
  assign ld3       = w_ld[2];
  assign busy      = ~w_free;
  assign fifo_full = (r_cnt == c_DEPTH);
  assign fifo_emp  = (r_cnt == '0);
  assign fifo_num  = r_q[0][c_ENT_W-1:TIME_W];
  assign fifo_tim  = r_q[0][TIME_W-1:0];
  assign dn1       = w_dn[0];
  assign dt1       = w_dt[0];
  assign dn2       = w_dn[1];
  assign dt2       = w_dt[1];
  assign dn3       = w_dn[2];
  assign dt3       = w_dt[2];

`ifdef DROP_COUNT_EN
  logic       w_drop;
  logic [7:0] r_drop;

  assign w_drop = in_valid && !rst_n && !w_byp && !w_push;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_drop <= 8'd0;
    else if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
  end

  assign drop_cnt = r_drop;
`endif

endmodule

`default_nettype wire

// File: tb/tb_service_counter_queue.sv
// ============================================================================
// Module  : tb_service_counter_queue
// Brief   : Directed and randomized checks of service_counter_queue against a
//           queue-based behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_service_counter_queue;

  logic        clk = 1'b0;
  logic        rst_n, in_valid;
  logic [3:0]  in_num, in_time;
  logic [3:0]  num1, num2, num3, clk1, clk2, clk3;
  logic [23:0] qdbg;
  logic        fifo_re, ld1, ld2, ld3, fifo_full, fifo_emp;
  logic [2:0]  busy;
  logic [3:0]  fifo_num, fifo_tim, dn1, dt1, dn2, dt2, dn3, dt3;
`ifdef DROP_COUNT_EN
  logic [7:0]  drop_cnt;
`endif

  service_counter_queue #(.DEPTH(3), .NUM_W(4), .TIME_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_num(in_num), .in_time(in_time),
    .num1(num1), .num2(num2), .num3(num3), .clk1(clk1), .clk2(clk2), .clk3(clk3),
    .qdbg(qdbg), .fifo_re(fifo_re), .ld1(ld1), .ld2(ld2), .ld3(ld3), .busy(busy),
    .fifo_full(fifo_full), .fifo_emp(fifo_emp), .fifo_num(fifo_num), .fifo_tim(fifo_tim),
    .dn1(dn1), .dt1(dt1), .dn2(dn2), .dt2(dt2), .dn3(dn3), .dt3(dt3)
`ifdef DROP_COUNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Everything except fifo_emp (and drop_cnt) must read zero in reset.
  logic [87:0] w_all;
  assign w_all = {num1, num2, num3, clk1, clk2, clk3, qdbg, fifo_re, ld1, ld2, ld3, busy,
                  fifo_full, fifo_num, fifo_tim, dn1, dt1, dn2, dt2, dn3, dt3};

  // Behavioural model: per-counter ticket/remaining time plus a queue of {num,time}.
  int m_num [3];
  int m_rem [3];
  int m_q [$];
  int m_drop;
  int e_ld [3];
  int e_dn [3];
  int e_dt [3];
  int e_re, e_push, e_drop;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin m_num[i] = 0; m_rem[i] = 0; end
    m_q.delete();
    m_drop = 0;
  endtask

  // Decide this cycle's dispatch from model state and the driven inputs.
  task automatic model_eval();
    int tgt;
    e_re = 0; e_push = 0; e_drop = 0;
    for (int i = 0; i < 3; i++) begin e_ld[i] = 0; e_dn[i] = 0; e_dt[i] = 0; end
    tgt = -1;
    if (m_q.size() > 0)
      for (int i = 0; i < 3; i++) if (tgt < 0 && m_rem[i] == 0) tgt = i;
    if (tgt >= 0) begin
      e_re = 1; e_ld[tgt] = 1; e_dn[tgt] = m_q[0] / 16; e_dt[tgt] = m_q[0] % 16;
    end
    if (in_valid) begin
      if (in_time == 0) e_drop = 1;
      else begin
        tgt = -1;
        if (m_q.size() == 0)
          for (int i = 0; i < 3; i++) if (tgt < 0 && m_rem[i] == 0) tgt = i;
        if (tgt >= 0) begin e_ld[tgt] = 1; e_dn[tgt] = in_num; e_dt[tgt] = in_time; end
        else if (m_q.size() < 3 || e_re == 1) e_push = 1;
        else e_drop = 1;
      end
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (e_ld[i] == 1) begin m_num[i] = e_dn[i]; m_rem[i] = e_dt[i]; end
      else if (m_rem[i] > 0) begin
        m_rem[i]--;
        if (m_rem[i] == 0) m_num[i] = 0;
      end
    end
    if (e_re == 1) void'(m_q.pop_front());
    if (e_push == 1) m_q.push_back(in_num * 16 + in_time);
    if (e_drop == 1 && m_drop < 255) m_drop++;
  endtask

  task automatic drive(input logic v, input logic [3:0] n, input logic [3:0] t);
    @(negedge clk);
    in_valid = v; in_num = n; in_time = t;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; in_num = 4'd0; in_time = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_num = 4'd0; in_time = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (w_all !== 88'd0 || fifo_emp !== 1'b1) begin n_fail++;
      $display("FAIL reset_held: outputs=%h emp=%b, want 0 and emp=1", w_all, fifo_emp); end
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 4'd0);
    n_checks++; if (w_all !== 88'd0 || fifo_emp !== 1'b1) begin n_fail++;
      $display("FAIL reset_release: outputs=%h emp=%b, want 0 and emp=1", w_all, fifo_emp); end
`ifdef DROP_COUNT_EN
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++;
      $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
`endif
  endtask

  task automatic test_dispatch_sequence();
    drive(1'b1, 4'd1, 4'd9);
    n_checks++; if ({ld1, ld2, ld3, dn1, dt1} !== {3'b100, 4'd1, 4'd9}) begin n_fail++;
      $display("FAIL arr1_load: ld=%b%b%b dn1=%0d dt1=%0d want 100 1 9", ld1, ld2, ld3, dn1, dt1); end
    drive(1'b1, 4'd2, 4'd9);
    n_checks++; if ({ld1, ld2, ld3, clk1} !== {3'b010, 4'd9}) begin n_fail++;
      $display("FAIL arr2_load: ld=%b%b%b clk1=%0d want 010 9", ld1, ld2, ld3, clk1); end
    drive(1'b1, 4'd3, 4'd9);
    n_checks++; if ({ld1, ld2, ld3, clk1} !== {3'b001, 4'd8}) begin n_fail++;
      $display("FAIL arr3_load: ld=%b%b%b clk1=%0d want 001 8", ld1, ld2, ld3, clk1); end
    drive(1'b1, 4'd4, 4'd1);
    n_checks++; if ({busy, ld1, ld2, ld3, fifo_emp} !== {3'b111, 3'b000, 1'b1}) begin n_fail++;
      $display("FAIL all_busy: busy=%b ld=%b%b%b emp=%b want 111 000 1", busy, ld1, ld2, ld3, fifo_emp); end
    drive(1'b1, 4'd5, 4'd5);
    drive(1'b1, 4'd6, 4'd2);
    n_checks++; if (qdbg !== 24'h005541) begin n_fail++;
      $display("FAIL fifo_two: qdbg=%h want 005541", qdbg); end
    drive(1'b1, 4'd7, 4'd3);
    n_checks++; if ({fifo_full, qdbg, fifo_num, fifo_tim, fifo_re} !== {1'b1, 24'h625541, 4'd4, 4'd1, 1'b0}) begin n_fail++;
      $display("FAIL fifo_full: full=%b qdbg=%h head=%0d/%0d re=%b want 1 625541 4/1 0", fifo_full, qdbg, fifo_num, fifo_tim, fifo_re); end
    drive(1'b0, 4'd0, 4'd0);
    n_checks++; if (qdbg !== 24'h625541) begin n_fail++;
      $display("FAIL drop_when_full: qdbg=%h want 625541", qdbg); end
    drive(1'b0, 4'd0, 4'd0);
    drive(1'b0, 4'd0, 4'd0);
    n_checks++; if (clk1 !== 4'd1) begin n_fail++;
      $display("FAIL countdown: clk1=%0d want 1", clk1); end
    drive(1'b0, 4'd0, 4'd0);
    n_checks++; if ({clk1, num1, fifo_re, ld1, dn1, dt1} !== {4'd0, 4'd0, 1'b1, 1'b1, 4'd4, 4'd1}) begin n_fail++;
      $display("FAIL head_pop: clk1=%0d num1=%0d re=%b ld1=%b dn1=%0d dt1=%0d want 0 0 1 1 4 1", clk1, num1, fifo_re, ld1, dn1, dt1); end
    drive(1'b0, 4'd0, 4'd0);
    n_checks++; if ({qdbg, fifo_full} !== {24'h006255, 1'b0}) begin n_fail++;
      $display("FAIL after_pop: qdbg=%h full=%b want 006255 0", qdbg, fifo_full); end
    repeat (3) drive(1'b0, 4'd0, 4'd0);
    drive(1'b1, 4'd10, 4'd15);
    n_checks++; if ({ld1, ld2, ld3} !== 3'b100) begin n_fail++;
      $display("FAIL lowest_free: ld=%b%b%b want 100", ld1, ld2, ld3); end
    drive(1'b0, 4'd0, 4'd0);
    drive(1'b1, 4'd8, 4'd2);
    n_checks++; if ({clk2, ld1, ld2, ld3, dn2, dt2, fifo_emp} !== {4'd0, 3'b010, 4'd8, 4'd2, 1'b1}) begin n_fail++;
      $display("FAIL bypass: clk2=%0d ld=%b%b%b dn2=%0d dt2=%0d emp=%b want 0 010 8 2 1", clk2, ld1, ld2, ld3, dn2, dt2, fifo_emp); end
    drive(1'b1, 4'd9, 4'd0);
    n_checks++; if ({num2, clk2, ld1, ld2, ld3, fifo_re, fifo_emp} !== {4'd8, 4'd2, 3'b000, 1'b0, 1'b1}) begin n_fail++;
      $display("FAIL zero_time: num2=%0d clk2=%0d ld=%b%b%b re=%b emp=%b want 8 2 000 0 1", num2, clk2, ld1, ld2, ld3, fifo_re, fifo_emp); end
    drive(1'b0, 4'd0, 4'd0);
    n_checks++; if ({qdbg, fifo_emp} !== {24'h0, 1'b1}) begin n_fail++;
      $display("FAIL zero_time_nopush: qdbg=%h emp=%b want 0 1", qdbg, fifo_emp); end
`ifdef DROP_COUNT_EN
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++;
      $display("FAIL drop_count: got %0d want 2", drop_cnt); end
`endif
  endtask

  task automatic test_random();
    logic [23:0] eq;
    apply_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      in_valid = (c < 400) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
      in_num   = 4'($urandom);
      in_time  = (($urandom % 8) == 0) ? 4'd0 : 4'($urandom_range(1, 12));
      #1;
      model_eval();
      eq = '0;
      for (int k = 0; k < m_q.size(); k++) eq[8*k +: 8] = 8'(m_q[k]);
      n_checks++; if ({num1, num2, num3, clk1, clk2, clk3} !== {4'(m_num[0]), 4'(m_num[1]), 4'(m_num[2]),
                      4'(m_rem[0]), 4'(m_rem[1]), 4'(m_rem[2])}) begin n_fail++;
        $display("FAIL rnd_counters c%0d: got %0d %0d %0d / %0d %0d %0d want %0d %0d %0d / %0d %0d %0d", c,
                 num1, num2, num3, clk1, clk2, clk3, m_num[0], m_num[1], m_num[2], m_rem[0], m_rem[1], m_rem[2]); end
      n_checks++; if ({ld1, ld2, ld3, fifo_re, busy} !== {e_ld[0] == 1, e_ld[1] == 1, e_ld[2] == 1, e_re == 1,
                      m_rem[2] != 0, m_rem[1] != 0, m_rem[0] != 0}) begin n_fail++;
        $display("FAIL rnd_ctrl c%0d: ld=%b%b%b re=%b busy=%b want ld=%0d%0d%0d re=%0d", c,
                 ld1, ld2, ld3, fifo_re, busy, e_ld[0], e_ld[1], e_ld[2], e_re); end
      n_checks++; if ({dn1, dt1, dn2, dt2, dn3, dt3} !== {4'(e_dn[0]), 4'(e_dt[0]), 4'(e_dn[1]), 4'(e_dt[1]),
                      4'(e_dn[2]), 4'(e_dt[2])}) begin n_fail++;
        $display("FAIL rnd_loaddata c%0d: got %h%h %h%h %h%h want %0d/%0d %0d/%0d %0d/%0d", c, dn1, dt1, dn2, dt2,
                 dn3, dt3, e_dn[0], e_dt[0], e_dn[1], e_dt[1], e_dn[2], e_dt[2]); end
      n_checks++; if (qdbg !== eq) begin n_fail++;
        $display("FAIL rnd_qdbg c%0d: got %h want %h", c, qdbg, eq); end
      n_checks++; if ({fifo_full, fifo_emp, fifo_num, fifo_tim} !== {m_q.size() == 3, m_q.size() == 0, eq[7:4], eq[3:0]}) begin n_fail++;
        $display("FAIL rnd_flags c%0d: full=%b emp=%b head=%0d/%0d want size %0d head %h", c,
                 fifo_full, fifo_emp, fifo_num, fifo_tim, m_q.size(), eq[7:0]); end
`ifdef DROP_COUNT_EN
      n_checks++; if (drop_cnt !== 8'(m_drop)) begin n_fail++;
        $display("FAIL rnd_drop_cnt c%0d: got %0d want %0d", c, drop_cnt, m_drop); end
`endif
      model_step();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'd1, 4'd9);
    drive(1'b1, 4'd2, 4'd9);
    drive(1'b1, 4'd3, 4'd9);
    drive(1'b1, 4'd4, 4'd5);
    drive(1'b1, 4'd5, 4'd5);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    n_checks++; if (w_all !== 88'd0 || fifo_emp !== 1'b1) begin n_fail++;
      $display("FAIL async_reset: outputs=%h emp=%b, want 0 and emp=1", w_all, fifo_emp); end
`ifdef DROP_COUNT_EN
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++;
      $display("FAIL async_reset_drop: got %0d want 0", drop_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dispatch_sequence();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/service_counter_queue.md
Name: service_counter_queue

Overview:
- Customer-service dispatcher with three service counters and a 3-entry FIFO waiting queue.
- Each arriving customer carries a 4-bit ticket number and a 4-bit service time.
- A customer goes straight to a free counter, waits in the FIFO, or is dropped when the FIFO is full.
- Top-level block of the queueing design; the debug outputs expose all internal state for waveform checking.

Parameters:
- DEPTH, 3, FIFO entries. qdbg width is 8*DEPTH.
- NUM_W, 4, ticket number width.
- TIME_W, 4, service time width.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous reset, active-high: asserted at 1 despite the _n suffix
- in_valid  in  1  arrival strobe, one customer per cycle
- in_num  in  4  arriving ticket number
- in_time  in  4  arriving service time in cycles
- num1/num2/num3  out  4  ticket currently at counter 1/2/3; 0 when idle
- clk1/clk2/clk3  out  4  remaining service cycles at counter 1/2/3
- qdbg  out  24  FIFO image; entry k (0=head) at [8k+7:8k] = {num,time}; unused slots 0
- fifo_re  out  1  FIFO pop this cycle
- ld1/ld2/ld3  out  1  counter i is loaded at the coming edge
- busy  out  3  bit i-1 = (clki != 0)
- fifo_full  out  1  FIFO holds DEPTH entries
- fifo_emp  out  1  FIFO holds 0 entries
- fifo_num/fifo_tim  out  4  head entry; 0 when empty
- dn1/dt1 .. dn3/dt3  out  4  num/time being loaded into counter i when ldi=1; else 0

Behaviour:
- Reset: all counters, FIFO and count are cleared. All outputs are 0 except fifo_emp=1.
- Counters:
  - At each edge, a busy counter decrements clki.
  - When clki reaches 0, numi is cleared to 0 on that same edge.
  - A load sets numi=dn, clki=dt at the edge. A customer with time t keeps its counter busy for exactly t cycles.
- Free counter: busy bit = 0 in the current cycle. A counter reaching 0 becomes free the cycle after.
- Dispatch, combinational within a cycle, strict lowest-index free counter first:
  1. FIFO head first. If FIFO is non-empty and any counter is free: fifo_re=1, and the head goes to the lowest free counter.
  2. Arrival (in_valid=1, in_time!=0):
     - if the FIFO is empty and a free counter remains after step 1, load that counter directly, bypassing the FIFO;
     - else push to the FIFO if not full, or if full but popping this cycle;
     - else drop silently.
  3. At most one pop and one push per cycle.
- in_valid with in_time=0 is dropped and affects nothing.
- FIFO ordering:
  - Strict arrival order; the head is the oldest entry.
  - Push and pop in the same cycle keeps the count.
  - An arrival never overtakes a waiting entry.
- ldi/dni/dti/fifo_re are combinational from the current state and inputs; registered state updates at the rising edge.
- Async reset mid-operation aborts all service and empties the queue immediately.

Optional Feature:
- Macro: DROP_COUNT_EN.
- Defined: adds output drop_cnt[7:0]. It counts dropped customers (FIFO full or in_time=0), saturates at 255 and is cleared by reset.
- Undefined: no port and no logic.

Test Plan:
1. Assert rst_n=1 mid-service with counters busy and FIFO partly full -> all outputs 0 and fifo_emp=1 immediately, before the next edge.
2. Consecutive-cycle arrivals (1,9),(2,9),(3,9) -> ld1, ld2, ld3 each pulse one cycle; busy=3'b111; clk1=9 after the first edge, counting down by 1 per cycle.
3. Then (4,1),(5,5),(6,2) -> fifo_full=1, qdbg=24'h625541, fifo_num=4, fifo_tim=1; then (7,3) -> dropped, qdbg unchanged.
4. Counter 1 reaches clk1=0 -> next cycle fifo_re=1, ld1=1, dn1=4, dt1=1; qdbg=24'h006255; fifo_full=0.
5. FIFO empty, counter 2 idle, arrival (8,2) -> ld2=1 in the arrival cycle; num2=8, clk2=2 after the edge; fifo_emp stays 1.
6. Arrival (9,0) -> no load, no push; with DROP_COUNT_EN, drop_cnt increments.
